dense_argmax_reader: RTL and testbench

//  Reader at the far end of the dense layer's result writes. After the final dense layer finishes, it walks the packed result words in

---
 rtl/dense_argmax_reader_pkg.sv | 24 ++
 rtl/dense_argmax_reader_cmp.sv | 31 +++
 rtl/dense_argmax_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_dense_argmax_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_argmax_reader_pkg.sv
// Shared FSM encoding, default widths and lane
// helper for the dense-layer argmax reader.
package dense_argmax_reader_pkg;

  localparam int SIZE_1_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_SCAN    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Bit offset of a lane inside a packed word.
  function automatic int lane_lsb(
    input int lane,
    input int width
  );
    return lane * width;
  endfunction

endpackage

// File: rtl/dense_argmax_reader_cmp.sv
// lane_max_cmp: signed compare/select of a candidate
// against the current best, strict-greater wins.
// Ports:
//  cand_val/cand_idx  candidate lane value and index
//  cur_val/cur_idx    current holder
//  cur_vld            holder valid; invalid always loses
//  take               candidate replaces holder
//  sel_val/sel_idx    selected pair
module lane_max_cmp
  import dense_argmax_reader_pkg::*;
#(
  parameter int VAL_W = SIZE_1_DEF,
  parameter int IDX_W = 7
) (
  input  logic signed [VAL_W-1:0] cand_val,
  input  logic        [IDX_W-1:0] cand_idx,
  input  logic signed [VAL_W-1:0] cur_val,
  input  logic        [IDX_W-1:0] cur_idx,
  input  logic                    cur_vld,
  output logic                    take,
  output logic signed [VAL_W-1:0] sel_val,
  output logic        [IDX_W-1:0] sel_idx
);

  // Equal values never replace, so ties keep
  // the lowest index seen first.
  assign take    = !cur_vld || (cand_val > cur_val);
  assign sel_val = take ? cand_val : cur_val;
  assign sel_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/dense_argmax_reader.sv
// dense_argmax_reader: walks packed dense results in
// pixel RAM and returns argmax index and max value.
// Ports:
//  clk, rst_n     clock, sync active-low reset
//  read_en        level enable, low clears/aborts
//  out            number of valid results
//  memstartp      word address of result 0
//  re_p           RAM read enable
//  read_addressp  RAM read address
//  qp             RAM read data (NUM_LANES lanes)
//  STOP           done, held while read_en=1
//  class_idx      argmax index
//  max_val        max result value (signed)
// DENSE_ARGMAX_TOP2_EN adds second_idx, second_val
// and margin (max_val - second_val, saturated).
module dense_argmax_reader
  import dense_argmax_reader_pkg::*;
#(
  parameter int SIZE_1           = SIZE_1_DEF,
  parameter int NUM_LANES        = 4,
  parameter int SIZE_address_pix = 13,
  parameter int RD_LAT           = 1,
  parameter int IDX_W            = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          read_en,
  input  logic [IDX_W-1:0]              out,
  input  logic [SIZE_address_pix-1:0]   memstartp,
  output logic                          re_p,
  output logic [SIZE_address_pix-1:0]   read_addressp,
  input  logic [SIZE_1*NUM_LANES-1:0]   qp,
  output logic                          STOP,
  output logic [IDX_W-1:0]              class_idx,
  output logic signed [SIZE_1-1:0]      max_val
`ifdef DENSE_ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]              second_idx,
  output logic signed [SIZE_1-1:0]      second_val,
  output logic [SIZE_1-1:0]             margin
`endif
);

  localparam int LANE_W =
    (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int WAIT_LAST =
    (RD_LAT > 1) ? RD_LAT - 2 : 0;

  state_t state_q;
  state_t state_d;

  logic                         clear;
  logic [SIZE_1*NUM_LANES-1:0]  word_q;
  logic [LANE_W-1:0]            lane_q;
  logic [IDX_W-1:0]             res_cnt;
  logic [IDX_W-1:0]             word_cnt;
  logic [IDX_W-1:0]             out_q;
  logic [1:0]                   wait_cnt;
  logic                         last_lane;
  logic                         last_res;
  logic                         max_vld;
  logic signed [SIZE_1-1:0]     cand;

  logic                         mx_take;
  logic signed [SIZE_1-1:0]     mx_val;
  logic [IDX_W-1:0]             mx_idx;

  // Abort and reset share one clear path.
  assign clear = !rst_n || !read_en;

  assign last_lane =
    (lane_q == LANE_W'(NUM_LANES - 1));
  assign last_res  = (res_cnt == out_q - 1'b1);
  assign max_vld   = (res_cnt != '0);
  assign STOP      = (state_q == S_DONE);

  assign cand =
    word_q[lane_lsb(int'(lane_q), SIZE_1) +: SIZE_1];

  lane_max_cmp #(
    .VAL_W (SIZE_1),
    .IDX_W (IDX_W)
  ) u_max_cmp (
    .cand_val (cand),
    .cand_idx (res_cnt),
    .cur_val  (max_val),
    .cur_idx  (class_idx),
    .cur_vld  (max_vld),
    .take     (mx_take),
    .sel_val  (mx_val),
    .sel_idx  (mx_idx)
  );

  always_ff @(posedge clk) begin
    if (clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (out == '0) state_d = S_DONE;
        else           state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (RD_LAT > 1) state_d = S_WAIT;
        else            state_d = S_CAPTURE;
      end
      S_WAIT: begin
        if (wait_cnt == 2'(WAIT_LAST))
          state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_SCAN;
      S_SCAN: begin
        if (last_res)       state_d = S_DONE;
        else if (last_lane) state_d = S_ISSUE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      re_p          <= 1'b0;
      read_addressp <= '0;
      class_idx     <= '0;
      max_val       <= '0;
      word_q        <= '0;
      lane_q        <= '0;
      res_cnt       <= '0;
      word_cnt      <= '0;
      out_q         <= '0;
      wait_cnt      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: out_q <= out;
        S_ISSUE: begin
          re_p          <= 1'b1;
          read_addressp <= memstartp +
            SIZE_address_pix'(word_cnt);
          wait_cnt      <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + 1'b1;
        S_CAPTURE: begin
          word_q <= qp;
          re_p   <= 1'b0;
          lane_q <= '0;
        end
        S_SCAN: begin
          if (mx_take) begin
            max_val   <= mx_val;
            class_idx <= mx_idx;
          end
          res_cnt <= res_cnt + 1'b1;
          lane_q  <= lane_q + 1'b1;
          if (last_lane)
            word_cnt <= word_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DENSE_ARGMAX_TOP2_EN
  localparam logic signed [SIZE_1+1:0] MARGIN_MAX =
    {2'b00, {SIZE_1{1'b1}}};

  logic                     sec_vld;
  logic                     sc_take;
  logic signed [SIZE_1-1:0] sc_val;
  logic [IDX_W-1:0]         sc_idx;
  logic signed [SIZE_1+1:0] diff;

  lane_max_cmp #(
    .VAL_W (SIZE_1),
    .IDX_W (IDX_W)
  ) u_sec_cmp (
    .cand_val (cand),
    .cand_idx (res_cnt),
    .cur_val  (second_val),
    .cur_idx  (second_idx),
    .cur_vld  (sec_vld),
    .take     (sc_take),
    .sel_val  (sc_val),
    .sel_idx  (sc_idx)
  );

  // A new max pushes the old max into second
  // place; otherwise the lane competes for second.
  always_ff @(posedge clk) begin
    if (clear) begin
      sec_vld    <= 1'b0;
      second_val <= '0;
      second_idx <= '0;
    end else if (state_q == S_SCAN) begin
      if (mx_take && max_vld) begin
        second_val <= max_val;
        second_idx <= class_idx;
        sec_vld    <= 1'b1;
      end else if (!mx_take && sc_take) begin
        second_val <= sc_val;
        second_idx <= sc_idx;
        sec_vld    <= 1'b1;
      end
    end
  end

  assign diff =
    {{2{max_val[SIZE_1-1]}}, max_val} -
    {{2{second_val[SIZE_1-1]}}, second_val};

  always_comb begin
    margin = '0;
    if (sec_vld) begin
      if (diff > MARGIN_MAX) margin = '1;
      else margin = diff[SIZE_1-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_dense_argmax_reader.sv
// Self-checking bench for dense_argmax_reader:
// directed cases plus random scans vs a reference.
module tb_dense_argmax_reader;

  localparam int SZ = 8;
  localparam int NL = 4;
  localparam int AW = 13;
  localparam int RL = 1;
  localparam int IW = 7;
  localparam int WW = SZ * NL;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 read_en;
  logic [IW-1:0]        out;
  logic [AW-1:0]        memstartp;
  logic                 re_p;
  logic [AW-1:0]        read_addressp;
  logic [WW-1:0]        qp;
  logic                 STOP;
  logic [IW-1:0]        class_idx;
  logic signed [SZ-1:0] max_val;
`ifdef DENSE_ARGMAX_TOP2_EN
  logic [IW-1:0]        second_idx;
  logic signed [SZ-1:0] second_val;
  logic [SZ-1:0]        margin;
`endif

  logic [WW-1:0] mem [0:DEPTH-1];
  int            vals[$];
  logic [AW-1:0] rd_q[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  // RD_LAT=1: data follows the registered address.
  assign qp = mem[read_addressp];

  always @(posedge clk)
    if (re_p === 1'b1) rd_q.push_back(read_addressp);

  dense_argmax_reader #(
    .SIZE_1           (SZ),
    .NUM_LANES        (NL),
    .SIZE_address_pix (AW),
    .RD_LAT           (RL),
    .IDX_W            (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_en       (read_en),
    .out           (out),
    .memstartp     (memstartp),
    .re_p          (re_p),
    .read_addressp (read_addressp),
    .qp            (qp),
    .STOP          (STOP),
    .class_idx     (class_idx),
    .max_val       (max_val)
`ifdef DENSE_ARGMAX_TOP2_EN
    ,
    .second_idx    (second_idx),
    .second_val    (second_val),
    .margin        (margin)
`endif
  );

  task automatic check(
    input string tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain scan of the result list.
  task automatic ref_model(
    output int bi, output int bv,
    output int si, output int sv,
    output int mg
  );
    bit found;
    bi = 0; bv = 0; si = 0; sv = 0; mg = 0;
    found = 0;
    for (int i = 0; i < vals.size(); i++)
      if (i == 0 || vals[i] > bv) begin
        bi = i; bv = vals[i];
      end
    if (vals.size() >= 2) begin
      for (int i = 0; i < vals.size(); i++)
        if (i != bi && (!found || vals[i] > sv)) begin
          si = i; sv = vals[i]; found = 1;
        end
      mg = bv - sv;
      if (mg > (1 << SZ) - 1) mg = (1 << SZ) - 1;
    end
  endtask

  // Unused lanes hold +127 so scanning them
  // would change the answer.
  task automatic load_mem(input int base);
    int nw;
    int v;
    logic [WW-1:0] word;
    nw = (vals.size() + NL - 1) / NL;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int l = 0; l < NL; l++) begin
        v = (w * NL + l < vals.size()) ?
            vals[w * NL + l] : 127;
        word[l * SZ +: SZ] = SZ'(v);
      end
      mem[(base + w) % DEPTH] = word;
    end
  endtask

  task automatic run_case(
    input string tag,
    input int base
  );
    int n, nw, lat, edges;
    int bi, bv, si, sv, mg;
    logic [IW-1:0] idx_done;
    n   = vals.size();
    nw  = (n + NL - 1) / NL;
    lat = nw * (RL + 1) + n + 1;
    ref_model(bi, bv, si, sv, mg);
    load_mem(base);
    out       = IW'(n);
    memstartp = AW'(base);
    rd_q.delete();
    read_en   = 1'b1;
    edges     = 0;
    do begin
      tick();
      edges++;
    end while (STOP !== 1'b1 && edges < 1000);
    check({tag, "_lat"}, edges, lat);
    check({tag, "_idx"}, class_idx, bi);
    check({tag, "_val"}, max_val, bv);
`ifdef DENSE_ARGMAX_TOP2_EN
    check({tag, "_sidx"}, second_idx, si);
    check({tag, "_sval"}, second_val, sv);
    check({tag, "_margin"}, margin, mg);
`endif
    check({tag, "_nrd"}, rd_q.size(), nw * RL);
    if (rd_q.size() == nw * RL)
      for (int k = 0; k < rd_q.size(); k++)
        check({tag, "_addr"}, rd_q[k],
              (base + k / RL) % DEPTH);
    idx_done = class_idx;
    tick();
    tick();
    check({tag, "_hold"}, STOP, 1);
    check({tag, "_holdidx"}, class_idx, idx_done);
    read_en = 1'b0;
    tick();
    check({tag, "_clrstop"}, STOP, 0);
    check({tag, "_clridx"}, class_idx, 0);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    read_en   = 1'b1;
    out       = 5;
    memstartp = 7;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = WW'($urandom);
    tick();
    tick();
    check("rst_stop", STOP, 0);
    check("rst_rep", re_p, 0);
    check("rst_addr", read_addressp, 0);
    check("rst_idx", class_idx, 0);
    check("rst_val", max_val, 0);
    rst_n   = 1'b1;
    read_en = 1'b0;
    tick();

    vals = '{-3, 5, 2, 7, 7, -1, 0, 6, 1, 4};
    run_case("t1", 32);

    vals.delete();
    run_case("t2_empty", 50);

    vals = '{-128, -128, -128, -128};
    run_case("t3_min", 100);

    // Abort in the middle of word 1's scan.
    vals.delete();
    for (int i = 0; i < 10; i++)
      vals.push_back(int'($urandom_range(1, 100)));
    load_mem(200);
    out       = 10;
    memstartp = 200;
    read_en   = 1'b1;
    repeat (1 + 2 * (RL + 1) + NL + 1) tick();
    read_en = 1'b0;
    tick();
    check("t4_abort_stop", STOP, 0);
    check("t4_abort_rep", re_p, 0);
    check("t4_abort_idx", class_idx, 0);
    check("t4_abort_val", max_val, 0);
    run_case("t4_rescan", 200);

    // Reset pulse while the first read is issuing.
    vals.delete();
    for (int i = 0; i < 7; i++)
      vals.push_back(int'($urandom_range(0, 255)) - 128);
    load_mem(300);
    out       = 7;
    memstartp = 300;
    read_en   = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_rep", re_p, 0);
    check("t5_rst_stop", STOP, 0);
    rst_n = 1'b1;
    run_case("t5_restart", 300);

    // Ties at the top; base wraps the address.
    vals = '{10, 30, 30, 20, -5};
    run_case("t6_wrap", DEPTH - 1);

    for (int r = 0; r < 10; r++) begin
      int n;
      bit narrow;
      n      = int'($urandom_range(1, 127));
      narrow = $urandom_range(0, 1) == 1;
      vals.delete();
      for (int i = 0; i < n; i++)
        if (narrow)
          vals.push_back(int'($urandom_range(0, 3)) - 2);
        else
          vals.push_back(int'($urandom_range(0, 255)) - 128);
      base = int'($urandom_range(0, DEPTH - 1));
      run_case($sformatf("rnd%0d", r), base);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
